// File: rtl/luc_sweep_pkg.sv
// Shared constants and state type for the luc exhaustive sweep sequencer.
// MISR_POLY encodes x^27+x^5+x^2+x+1 with the x^27 term implicit.
package luc_sweep_pkg;

  localparam int DEF_IN_W  = 8;
  localparam int DEF_OUT_W = 27;
  localparam int DEF_TOG_W = 16;

  localparam logic [26:0] MISR_POLY = 27'h0000027;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sweep_state_t;

endpackage

// File: rtl/luc_misr.sv
// Multiple-input signature register that compacts one response word per enabled cycle.
module luc_misr
  import luc_sweep_pkg::*;
#(
  parameter int               OUT_W = DEF_OUT_W,
  parameter logic [OUT_W-1:0] POLY  = OUT_W'(MISR_POLY)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [OUT_W-1:0] data_i,
  output logic [OUT_W-1:0] sig_o
);

  logic [OUT_W-1:0] sig_q, sig_d;

  // Clear wins over enable so a new sweep always starts from a zero signature.
  always_comb begin
    sig_d = sig_q;
    if (clear_i) begin
      sig_d = '0;
    end else if (enable_i) begin
      sig_d = {sig_q[OUT_W-2:0], 1'b0} ^ (sig_q[OUT_W-1] ? POLY : '0) ^ data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/luc_sweep_ctrl.sv
// Drives every input vector of the luc benchmark in binary or Gray order and
// accumulates a MISR signature plus a saturating output-toggle count.
module luc_sweep_ctrl
  import luc_sweep_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int TOG_W = DEF_TOG_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             order_gray_i,
  input  logic             abort_i,
  output logic [IN_W-1:0]  dut_in_o,
  input  logic [OUT_W-1:0] dut_out_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [OUT_W-1:0] signature_o,
  output logic [TOG_W-1:0] toggles_o,
  output logic             toggle_sat_o
);

  localparam int POP_W = $clog2(OUT_W + 1);
  localparam int SUM_W = TOG_W + POP_W;

  sweep_state_t     state_q, state_d;
  logic [IN_W-1:0]  cnt_q, cnt_d;
  logic [IN_W-1:0]  dutIn_q, dutIn_d;
  logic             gray_q, gray_d;
  logic [OUT_W-1:0] prevOut_q, prevOut_d;
  logic [TOG_W-1:0] togCnt_q, togCnt_d;
  logic             togSat_q, togSat_d;
  logic             misrClear, misrEnable;
  logic [POP_W-1:0] popCount;
  logic [SUM_W-1:0] togSum;
  logic [IN_W-1:0]  nextCnt;
  logic [OUT_W-1:0] outDiff;

  // Hamming distance between this response and the previous one.
  always_comb begin
    outDiff  = dut_out_i ^ prevOut_q;
    popCount = '0;
    for (int i = 0; i < OUT_W; i++) begin
      popCount = popCount + POP_W'(outDiff[i]);
    end
  end

  assign togSum  = {{POP_W{1'b0}}, togCnt_q} + SUM_W'(popCount);
  assign nextCnt = cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dutIn_d    = dutIn_q;
    gray_d     = gray_q;
    prevOut_d  = prevOut_q;
    togCnt_d   = togCnt_q;
    togSat_d   = togSat_q;
    misrClear  = 1'b0;
    misrEnable = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = RUN;
          cnt_d     = '0;
          dutIn_d   = '0;
          togCnt_d  = '0;
          togSat_d  = 1'b0;
          gray_d    = order_gray_i;
          misrClear = 1'b1;
        end
      end
      RUN: begin
        // An abort freezes the partial results and skips the last-vector exit.
        if (abort_i) begin
          state_d = IDLE;
        end else begin
          misrEnable = 1'b1;
          prevOut_d  = dut_out_i;
          if (cnt_q != '0) begin
            if (togSum[SUM_W-1:TOG_W] != '0) begin
              togCnt_d = '1;
              togSat_d = 1'b1;
            end else begin
              togCnt_d = togSum[TOG_W-1:0];
            end
          end
          if (cnt_q == '1) begin
            state_d = DONE;
          end else begin
            cnt_d   = nextCnt;
            dutIn_d = gray_q ? (nextCnt ^ (nextCnt >> 1)) : nextCnt;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dutIn_q   <= '0;
      gray_q    <= 1'b0;
      prevOut_q <= '0;
      togCnt_q  <= '0;
      togSat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dutIn_q   <= dutIn_d;
      gray_q    <= gray_d;
      prevOut_q <= prevOut_d;
      togCnt_q  <= togCnt_d;
      togSat_q  <= togSat_d;
    end
  end

  luc_misr #(
    .OUT_W (OUT_W)
  ) u_misr (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (misrClear),
    .enable_i (misrEnable),
    .data_i   (dut_out_i),
    .sig_o    (signature_o)
  );

  assign dut_in_o     = dutIn_q;
  assign busy_o       = (state_q == RUN);
  assign done_o       = (state_q == DONE);
  assign toggles_o    = togCnt_q;
  assign toggle_sat_o = togSat_q;

endmodule

// File: doc/luc_sweep_ctrl.md
# luc_sweep_ctrl

Sequencer that exhaustively exercises the 8-input / 27-output `luc` combinational benchmark for power-aware synthesis evaluation. It drives all 256 input vectors in binary or Gray order and captures every response. It compacts the responses into a 27-bit MISR signature and counts output bit toggles between consecutive vectors, which serves as a switching-activity proxy. It sits between the RL flow's test harness and one instance of the synthesized `luc` netlist.

## Interface
- `IN_W`, default 8: DUT input width; the sweep length is 2^IN_W.
- `OUT_W`, default 27: DUT output width; also the signature width.
- `TOG_W`, default 16: toggle counter width; the counter saturates.
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst_n`  in  1: reset. It is synchronous and active-low.
- `start`  in  1: one-cycle request to begin a sweep; accepted only in IDLE.
- `order_gray`  in  1: sampled with `start`; 1 selects Gray order, 0 selects binary order.
- `abort`  in  1: synchronous abort; returns to IDLE without `done`.
- `dut_in`  out  IN_W: registered vector driven to the DUT.
- `dut_out`  in  OUT_W: combinational DUT response to `dut_in`.
- `busy`  out  1: high in RUN.
- `done`  out  1: one-cycle pulse when a sweep completes.
- `signature`  out  OUT_W: MISR result; valid from the `done` cycle until the next accepted `start`.
- `toggles`  out  TOG_W: accumulated output toggle count.
- `toggle_sat`  out  1: sticky flag; set when `toggles` saturated.

## Operation
- States:
  - IDLE → RUN on `start`.
  - RUN → DONE after the last vector.
  - RUN → IDLE on `abort`.
  - DONE → IDLE unconditionally.
- On `start` accepted in IDLE:
  - cnt←0, dut_in←code(0), signature←0, toggles←0, toggle_sat←0.
  - Latch `order_gray`.
- code(n) = n when binary; code(n) = n ^ (n>>1) when Gray.
- Each RUN edge, with `dut_out` being the response to the current `dut_in`:
  - sig ← {sig[OUT_W-2:0],1'b0} ^ (sig[OUT_W-1] ? MISR_POLY : 0) ^ dut_out.
  - If cnt≠0: toggles ← sat(toggles + popcount(dut_out ^ prev_out)). toggle_sat is set if the true sum exceeds 2^TOG_W−1; toggles then holds at the maximum.
  - prev_out ← dut_out.
  - If cnt = 2^IN_W−1, go to DONE. Otherwise cnt←cnt+1 and dut_in←code(cnt+1).
- DONE: `done`=1, `busy`=0; results are frozen; `dut_in` holds its last vector.
- Precedence: `abort` overrides the last-vector transition. An aborted sweep leaves partial results, which are not flagged valid. `start` is ignored in RUN and DONE.
- Reset mid-sweep: all state returns to reset values on the next edge with `rst_n`=0.

## Timing
- Reset values: state=IDLE, dut_in=0, busy=0, done=0, signature=0, toggles=0, toggle_sat=0, cnt=0, prev_out=0.
- Start accepted at edge E0. `busy` rises after E0.
- Vector n is on `dut_in` during cycle n+1 and is sampled at edge E(n+1).
- The last vector is sampled at E256; `done` is high in the cycle after E256 (cycle 257); IDLE follows from E257.
- One vector per cycle, with no bubbles. The DUT path must settle within one `clk` period.
- `start` may be re-issued in the cycle immediately after `done`.

## Structure
- Package `luc_sweep_pkg`:
  - `MISR_POLY` = 27'h0000027, i.e. x^27+x^5+x^2+x+1.
  - State enum `sweep_state_t` {IDLE, RUN, DONE}.
  - Default width constants.
- Sub-module `luc_misr`: OUT_W-wide MISR with clear and enable.
- The popcount and saturating adder stay inline.

## Test plan
- Tie `dut_out`=0, binary sweep → signature=0, toggles=0, toggle_sat=0. `done` occurs exactly 257 cycles after the start edge, and `busy` is high for 256 cycles.
- Loopback `dut_out`={19'b0,dut_in}:
  - Binary sweep → toggles=502.
  - Gray sweep → toggles=255.
- Same binary loopback with TOG_W=8 → toggles=255, toggle_sat=1.
- `abort` at cycle 100 of RUN → IDLE next cycle, no `done`. A new `start` then yields the full-run values, with no residue.
- `start` pulsed during RUN and during the DONE cycle → ignored, with no restart. `rst_n` low at cycle 50 → all outputs at reset values on the next cycle.
- Connect the real `luc` netlist → signature and toggles match the golden model's MISR computation for both orders. Two back-to-back sweeps give identical results.
